// File: rtl/text_buffer_pkg.sv
// Shared types and constants for the text display character buffer.
package text_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ALL = 2'd1,
    CLR_ROW = 2'd2
  } state_t;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/text_buffer_clear_ctr.sv
// Row/column sweep pointer for the clear engine: loads (start_row, 0) on start,
// steps row-major on advance, and flags the last column / last cell.
module text_buffer_clear_ctr #(
  parameter int unsigned ROWS  = 32,
  parameter int unsigned COLS  = 4,
  parameter int unsigned ROW_W = $clog2(ROWS),
  parameter int unsigned COL_W = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ROW_W-1:0] start_row,
  input  logic             advance,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last_col,
  output logic             last_cell
);

  assign last_col  = (col == COL_W'(COLS - 1));
  assign last_cell = last_col && (row == ROW_W'(ROWS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (start) begin
      row <= start_row;
      col <= '0;
    end else if (advance) begin
      if (last_col) begin
        col <= '0;
        row <= (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/text_buffer_ram.sv
// Dual-port character buffer with a one-cell-per-clock clear engine.
// Define SCROLL_EN to add circular row scrolling with single-row clearing.
module text_buffer_ram
  import text_buffer_pkg::*;
#(
  parameter int unsigned      DATA_W    = 8,
  parameter int unsigned      ROWS      = 32,
  parameter int unsigned      COLS      = 4,
  parameter int unsigned      ROW_W     = $clog2(ROWS),
  parameter int unsigned      COL_W     = $clog2(COLS),
  parameter int unsigned      NTAPS     = 2,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [ROW_W-1:0]        w_row,
  input  logic [COL_W-1:0]        w_col,
  input  logic [DATA_W-1:0]       din,
  input  logic                    clr,
  input  logic                    scroll,
  input  logic [ROW_W-1:0]        r_row,
  input  logic [COL_W-1:0]        r_col,
  output logic [DATA_W-1:0]       dout,
  output logic [NTAPS*DATA_W-1:0] taps,
  output logic                    busy
);

  localparam logic [DATA_W-1:0] CR_V = DATA_W'(CHAR_CR);
  localparam logic [DATA_W-1:0] LF_V = DATA_W'(CHAR_LF);

  logic [DATA_W-1:0] mem [ROWS][COLS];

  state_t            state;
  logic [ROW_W-1:0]  row_base;
  logic [ROW_W-1:0]  ptr_row;
  logic [COL_W-1:0]  ptr_col;
  logic              last_col;
  logic              last_cell;
  logic              scroll_go;
  logic              ctr_start;
  logic [ROW_W-1:0]  ctr_load_row;
  logic              wr_ok;
  logic              rd_ok;
  logic              mem_we;
  logic [ROW_W-1:0]  mem_row;
  logic [COL_W-1:0]  mem_col;
  logic [DATA_W-1:0] mem_data;

  // Logical to physical row: single compare-and-subtract since both terms are < ROWS.
  function automatic logic [ROW_W-1:0] map_row(input logic [ROW_W-1:0] lrow,
                                               input logic [ROW_W-1:0] base);
    logic [ROW_W:0] sum;
    sum = {1'b0, lrow} + {1'b0, base};
    if (32'(sum) >= ROWS) sum = sum - (ROW_W+1)'(ROWS);
    return sum[ROW_W-1:0];
  endfunction

  function automatic logic in_range(input logic [ROW_W-1:0] row,
                                    input logic [COL_W-1:0] col);
    return (32'(row) < ROWS) && (32'(col) < COLS);
  endfunction

`ifdef SCROLL_EN
  assign scroll_go = scroll && !clr && (state == IDLE);
`else
  logic unused_inputs;
  assign scroll_go     = 1'b0;
  assign row_base      = '0;
  assign unused_inputs = ^{scroll, last_col};
`endif

  assign ctr_start    = clr || scroll_go;
  assign ctr_load_row = scroll_go ? row_base : '0;

  text_buffer_clear_ctr #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_clear_ctr (
    .clk       (clk),
    .reset     (reset),
    .start     (ctr_start),
    .start_row (ctr_load_row),
    .advance   (state != IDLE),
    .row       (ptr_row),
    .col       (ptr_col),
    .last_col  (last_col),
    .last_cell (last_cell)
  );

  // Control FSM; clr outranks scroll, which outranks user writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= CLR_ALL;
      busy     <= 1'b1;
`ifdef SCROLL_EN
      row_base <= '0;
`endif
    end else if (clr) begin
      state    <= CLR_ALL;
      busy     <= 1'b1;
`ifdef SCROLL_EN
      row_base <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef SCROLL_EN
          if (scroll_go) begin
            state    <= CLR_ROW;
            busy     <= 1'b1;
            row_base <= (row_base == ROW_W'(ROWS - 1)) ? '0 : row_base + ROW_W'(1);
          end
`endif
        end
        CLR_ALL: begin
          if (last_cell) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
`ifdef SCROLL_EN
        CLR_ROW: begin
          if (last_col) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Single memory write port shared by the clear engine and the user writer.
  always_comb begin
    wr_ok    = we && (din != CR_V) && (din != LF_V) && in_range(w_row, w_col);
    mem_we   = 1'b0;
    mem_row  = ptr_row;
    mem_col  = ptr_col;
    mem_data = CLEAR_VAL;
    if (state != IDLE) begin
      mem_we = 1'b1;
    end else if (wr_ok && !clr && !scroll_go) begin
      mem_we   = 1'b1;
      mem_row  = map_row(w_row, row_base);
      mem_col  = w_col;
      mem_data = din;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_row][mem_col] <= mem_data;
  end

  assign rd_ok = in_range(r_row, r_col);

  // Registered read and tap ports; nonblocking read gives read-before-write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
      taps <= '0;
    end else begin
      dout <= rd_ok ? mem[map_row(r_row, row_base)][r_col] : CLEAR_VAL;
      for (int unsigned k = 0; k < NTAPS; k++) begin
        taps[k*DATA_W +: DATA_W] <= mem[row_base][COL_W'(k)];
      end
    end
  end

endmodule

// File: tb/tb_text_buffer_ram.sv
// Directed self-checking bench for text_buffer_ram (default parameters).
// The scroll scenario runs only when SCROLL_EN is defined.
module tb_text_buffer_ram;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ROWS   = 32;
  localparam int unsigned COLS   = 4;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned COL_W  = 2;
  localparam int unsigned NTAPS  = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    we;
  logic [ROW_W-1:0]        w_row;
  logic [COL_W-1:0]        w_col;
  logic [DATA_W-1:0]       din;
  logic                    clr;
  logic                    scroll;
  logic [ROW_W-1:0]        r_row;
  logic [COL_W-1:0]        r_col;
  logic [DATA_W-1:0]       dout;
  logic [NTAPS*DATA_W-1:0] taps;
  logic                    busy;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  text_buffer_ram dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .w_row  (w_row),
    .w_col  (w_col),
    .din    (din),
    .clr    (clr),
    .scroll (scroll),
    .r_row  (r_row),
    .r_col  (r_col),
    .dout   (dout),
    .taps   (taps),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycles until busy falls, bounded so a stuck clear cannot hang the run.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 400) begin
      tick();
      cycles++;
    end
  endtask

  task automatic write_cell(input int r, input int c, input logic [7:0] d);
    we = 1'b1; w_row = ROW_W'(r); w_col = COL_W'(c); din = d;
    tick();
    we = 1'b0;
  endtask

  task automatic read_check(input string tag, input int r, input int c, input logic [7:0] exp);
    r_row = ROW_W'(r); r_col = COL_W'(c);
    tick();
    check(tag, 32'(dout), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; w_row = '0; w_col = '0; din = '0;
    clr = 1'b0; scroll = 1'b0; r_row = '0; r_col = '0;
    tick(); tick();
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_taps", 32'(taps), 32'h0);
    check("reset_busy", 32'(busy), 32'h1);

    reset = 1'b0;
    wait_idle(n);
    check("initial_clear_cycles", 32'(n), 32'd128);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 4; c++)
        read_check("initial_cell_zero", r, c, 8'h00);

    write_cell(3, 2, 8'h41);
    read_check("write_read_3_2", 3, 2, 8'h41);

    // CR and LF are filtered; cell keeps its earlier value.
    write_cell(0, 0, 8'h55);
    write_cell(0, 0, 8'h0D);
    write_cell(0, 0, 8'h0A);
    read_check("crlf_filtered", 0, 0, 8'h55);
    check("taps_after_crlf", 32'(taps), 32'h0055);

    // Same-cycle write and read of one cell returns the old data.
    we = 1'b1; w_row = 5'd5; w_col = 2'd1; din = 8'h77;
    r_row = 5'd5; r_col = 2'd1;
    tick();
    we = 1'b0;
    check("read_before_write_old", 32'(dout), 32'h00);
    tick();
    check("read_before_write_new", 32'(dout), 32'h77);

    write_cell(31, 3, 8'hAB);
    read_check("last_cell_write", 31, 3, 8'hAB);
    write_cell(0, 1, 8'h5A);
    tick();
    check("taps_two_cols", 32'(taps), 32'h5A55);

    // Write during a sweep is dropped; clr at cell 40 restarts the sweep.
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_busy", 32'(busy), 32'h1);
    repeat (10) tick();
    write_cell(0, 0, 8'h99);
    repeat (29) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    wait_idle(n);
    check("restart_clear_cycles", 32'(n), 32'd128);
    read_check("busy_write_dropped", 0, 0, 8'h00);
    read_check("cleared_3_2", 3, 2, 8'h00);
    read_check("cleared_31_3", 31, 3, 8'h00);

    // clr beats a same-cycle write.
    write_cell(2, 1, 8'h12);
    read_check("pre_clr_data", 2, 1, 8'h12);
    clr = 1'b1; we = 1'b1; w_row = 5'd7; w_col = 2'd3; din = 8'h66;
    tick();
    clr = 1'b0; we = 1'b0;
    wait_idle(n);
    check("clr_we_cycles", 32'(n), 32'd128);
    read_check("clr_beats_we", 7, 3, 8'h00);
    read_check("clr_wipes_old", 2, 1, 8'h00);
    check("idle_busy_low", 32'(busy), 32'h0);

`ifdef SCROLL_EN
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 4; c++)
        write_cell(r, c, 8'(8'h30 + r));
    scroll = 1'b1; tick(); scroll = 1'b0;
    wait_idle(n);
    check("scroll_busy_cycles", 32'(n), 32'd4);
    for (int c = 0; c < 4; c++) read_check("scroll_row0", 0, c, 8'h31);
    for (int c = 0; c < 4; c++) read_check("scroll_row31", 31, c, 8'h00);
    read_check("scroll_row30", 30, 0, 8'h4F);
    check("scroll_taps", 32'(taps), 32'h3131);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
